memory_stage: RTL

//  Pipeline MEM stage: consumes the EX->MEM bundle (ALU result/address, dest reg, mem_active, load),

---
 rtl/memory_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// ============================================================================
// Module   : memory_stage
// Purpose  : Pipeline MEM stage. Runs loads/stores on a req/gnt/resp port,
//            forwards results and stall back to EX, emits the MEM->WB bundle.
// Options  : define MISALIGN_CHECK_EN to trap misaligned H/W/D accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            EXMEM_ready,
    input  logic [XLEN-1:0] exmm_aluresult,
    input  logic [REGW-1:0] dest_reg,
    input  logic            mem_active,
    input  logic            load,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [1:0]      ex_mem_size,
    input  logic            ex_mem_unsigned,
    output logic            MEMEX_stall,
    output logic [REGW-1:0] MEMEX_rd,
    output logic [XLEN-1:0] MEMEX_rdval,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_gnt,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            MEMWB_ready,
    output logic [REGW-1:0] memwb_rd,
    output logic [XLEN-1:0] memwb_val,
    output logic            mem_misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, sdata_q, ldata_q, ldata_d;
    logic [REGW-1:0] rd_q;
    logic            mem_q, load_q, uns_q, mis_q;
    logic [1:0]      size_q;

    logic            w_capture;
    logic            w_mis_in;
    logic            w_resp_take;
    logic [2:0]      w_lane;
    logic [XLEN-1:0] w_shifted;
    logic [7:0]      w_strb_base;
    logic            w_fwd_ok;
    logic            w_wb_rd_ok;

    assign w_capture   = EXMEM_ready && !MEMEX_stall;
    assign w_resp_take = dmem_resp_valid &&
                         (((state_q == REQ) && dmem_gnt) || (state_q == WAIT));
    assign w_lane      = addr_q[2:0];

`ifdef MISALIGN_CHECK_EN
    assign w_mis_in = mem_active &&
                      (((ex_mem_size == 2'd1) && exmm_aluresult[0]) ||
                       ((ex_mem_size == 2'd2) && (exmm_aluresult[1:0] != 2'b00)) ||
                       ((ex_mem_size == 2'd3) && (exmm_aluresult[2:0] != 3'b000)));
    assign mem_misalign = (state_q == DONE) && mis_q;
`else
    assign w_mis_in     = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sdata_q <= '0;
            ldata_q <= '0;
            rd_q    <= '0;
            mem_q   <= 1'b0;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (w_capture) begin
                addr_q  <= exmm_aluresult;
                sdata_q <= ex_store_data;
                rd_q    <= dest_reg;
                mem_q   <= mem_active;
                load_q  <= load;
                uns_q   <= ex_mem_unsigned;
                mis_q   <= w_mis_in;
                size_q  <= ex_mem_size;
            end
            if (w_resp_take) begin
                ldata_q <= ldata_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (w_capture) state_d = (mem_active && !w_mis_in) ? REQ : DONE;
            REQ:  if (dmem_gnt) state_d = dmem_resp_valid ? DONE : WAIT;
            WAIT: if (dmem_resp_valid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load alignment: shift the addressed byte lane down, then size/extend.
    assign w_shifted = dmem_rdata >> {w_lane, 3'b000};

    always_comb begin
        ldata_d = w_shifted;
        case (size_q)
            2'd0: ldata_d = uns_q ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                  : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            2'd1: ldata_d = uns_q ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                  : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            2'd2: ldata_d = uns_q ? {{(XLEN-32){1'b0}}, w_shifted[31:0]}
                                  : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            default: ldata_d = w_shifted;
        endcase
    end

    always_comb begin
        w_strb_base = 8'hFF;
        case (size_q)
            2'd0:    w_strb_base = 8'h01;
            2'd1:    w_strb_base = 8'h03;
            2'd2:    w_strb_base = 8'h0F;
            default: w_strb_base = 8'hFF;
        endcase
    end

    // Request fields are only driven while REQ so the bus idles at zero.
    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = dmem_req && !load_q;
    assign dmem_addr  = dmem_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign dmem_wstrb = dmem_we ? (w_strb_base << w_lane) : 8'h00;
    assign dmem_wdata = dmem_we ? (sdata_q << {w_lane, 3'b000}) : '0;

    assign MEMEX_stall = (state_q == REQ) || (state_q == WAIT) ||
                         ((state_q == DONE) && EXMEM_ready);

    assign w_fwd_ok   = ((state_q != IDLE) && !mem_q) ||
                        ((state_q == DONE) && mem_q && load_q && !mis_q);
    assign MEMEX_rd    = w_fwd_ok ? rd_q : '0;
    assign MEMEX_rdval = w_fwd_ok ? (mem_q ? ldata_q : addr_q) : '0;

    assign w_wb_rd_ok  = !mem_q || (load_q && !mis_q);
    assign MEMWB_ready = (state_q == DONE);
    assign memwb_rd    = (MEMWB_ready && w_wb_rd_ok) ? rd_q : '0;
    assign memwb_val   = !MEMWB_ready ? '0 :
                         !mem_q       ? addr_q :
                         w_wb_rd_ok   ? ldata_q : '0;

endmodule

`default_nettype wire
